// File: rtl/i2s_sample_sink_if.sv
// rtl/i2s_sample_sink_if.sv - sample-source handshake between a synthesizer source and the I2S sink
interface i2s_sample_sink_if;
  logic [15:0] p_sample_buffer;
  logic        valid;
  logic        sample_req;

  // The source drives samples and answers frame requests.
  modport master (
    output p_sample_buffer,
    output valid,
    input  sample_req
  );

  // The sink consumes samples and asks for one per frame.
  modport slave (
    input  p_sample_buffer,
    input  valid,
    output sample_req
  );
endinterface

// File: rtl/i2s_sample_sink.sv
// rtl/i2s_sample_sink.sv - FIFO-buffered mono sample sink serialized as an I2S frame on mclk
module i2s_sample_sink #(
  parameter int FIFO_DEPTH    = 2,
  parameter int UNDERRUN_BITS = 8
) (
  input  logic                          mclk,
  input  logic                          rst,
  i2s_sample_sink_if.slave              src,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [UNDERRUN_BITS-1:0]      underrun_cnt,
  output logic                          overrun,
  input  logic                          clr_status
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  logic [7:0]    cnt;
  logic [7:0]    cnt_nxt;
  logic          sample_req_q;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   frame_q;
  logic [15:0]   last_q;
  logic          frame_load;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [4:0]    slot_nxt;
  logic [3:0]    bit_idx;
  logic          slot_bit;

  assign cnt_nxt    = cnt + 8'd1;
  assign frame_load = (cnt == 8'hFF);
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));

  // A pop at frame load frees an entry before the same-cycle push is judged.
  assign pop  = frame_load && !fifo_empty;
  assign push = src.valid && (!fifo_full || pop);
  assign drop = src.valid && !push;

  // Both I2S clocks come straight from counter flops, so they cannot glitch.
  assign bclk           = cnt[1];
  assign lrclk          = cnt[7];
  assign src.sample_req = sample_req_q;

  // Free-running frame counter; one full wrap is one stereo frame.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_nxt;
  end

  // Request pulse is registered so it lines up with cnt == 0 but stays low in reset.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) sample_req_q <= 1'b0;
    else      sample_req_q <= frame_load;
  end

  // Sample storage; contents are don't-care while the level says empty.
  always_ff @(posedge mclk) begin
    if (push) mem[wr_ptr] <= src.p_sample_buffer;
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Frame register takes the FIFO head, or repeats the last sample on underrun.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      frame_q <= '0;
      last_q  <= '0;
    end else if (pop) begin
      frame_q <= mem[rd_ptr];
      last_q  <= mem[rd_ptr];
    end else if (frame_load) begin
      frame_q <= last_q;
    end
  end

  // Saturating underrun count; a clear wins over a coincident underrun.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      underrun_cnt <= '0;
    end else if (clr_status) begin
      underrun_cnt <= '0;
    end else if (frame_load && fifo_empty && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + UNDERRUN_BITS'(1);
    end
  end

  // Sticky overrun flag; a clear wins over a coincident drop.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst)            overrun <= 1'b0;
    else if (clr_status) overrun <= 1'b0;
    else if (drop)       overrun <= 1'b1;
  end

  // Bit for the slot being entered: slot 0 is the I2S delay, 1..16 carry MSB..LSB.
  always_comb begin
    slot_nxt = cnt_nxt[6:2];
    bit_idx  = 4'(5'd16 - slot_nxt);
    slot_bit = 1'b0;
    if ((slot_nxt >= 5'd1) && (slot_nxt <= 5'd16)) slot_bit = frame_q[bit_idx];
  end

  // Serial data changes only on the bclk falling edge so the codec sees it stable.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst)                  sdata <= 1'b0;
    else if (cnt[1:0] == 2'b11) sdata <= slot_bit;
  end

endmodule

// File: tb/tb_i2s_sample_sink.sv
// tb/tb_i2s_sample_sink.sv - scoreboard bench for i2s_sample_sink frame, FIFO and status behaviour
module tb_i2s_sample_sink;
  logic       mclk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_status = 1'b0;
  logic       bclk, lrclk, sdata, overrun;
  logic [1:0] fifo_level;
  logic [7:0] underrun_cnt;
  logic [7:0] tcnt;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  i2s_sample_sink_if src_if();

  i2s_sample_sink #(.FIFO_DEPTH(2), .UNDERRUN_BITS(8)) dut (
    .mclk(mclk), .rst(rst), .src(src_if.slave), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .fifo_level(fifo_level), .underrun_cnt(underrun_cnt),
    .overrun(overrun), .clr_status(clr_status)
  );

  always #5 mclk = ~mclk;

  // Reference frame position, independent of the DUT.
  always @(posedge mclk or negedge rst) begin
    if (!rst) tcnt <= 8'd0;
    else      tcnt <= tcnt + 8'd1;
  end

  task automatic wait_cnt(input logic [7:0] v);
    int n = 0;
    do begin
      @(negedge mclk);
      n++;
    end while (tcnt != v && n < 400);
    if (tcnt != v) begin
      checks++; errors++;
      $display("FAIL wait_cnt got %0d want %0d", tcnt, v);
    end
  endtask

  task automatic clr_at(input logic [7:0] v);
    wait_cnt(v);
    clr_status = 1'b1;
    @(negedge mclk);
    clr_status = 1'b0;
  endtask

  // Called at the negedge where tcnt == 0; returns at tcnt == 255.
  task automatic check_frame(input string name);
    logic [15:0] l, r, e;
    int pad_err, clk_err, slot;
    l = 16'h0; r = 16'h0; pad_err = 0; clk_err = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge mclk);
      if (bclk !== tcnt[1] || lrclk !== tcnt[7] || src_if.sample_req !== (tcnt == 8'd0)) clk_err++;
      if (tcnt[1:0] == 2'd2) begin
        slot = int'(tcnt[6:2]);
        if (slot >= 1 && slot <= 16) begin
          if (tcnt[7]) r[16-slot] = sdata;
          else         l[16-slot] = sdata;
        end else if (sdata !== 1'b0) begin
          pad_err++;
        end
      end
    end
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (l !== e) begin errors++; $display("FAIL %s left got %h want %h", name, l, e); end
      checks++;
      if (r !== e) begin errors++; $display("FAIL %s right got %h want %h", name, r, e); end
    end
    checks++;
    if (pad_err !== 0) begin errors++; $display("FAIL %s pad_slots got %0d nonzero want 0", name, pad_err); end
    checks++;
    if (clk_err !== 0) begin errors++; $display("FAIL %s clocks got %0d bad cycles want 0", name, clk_err); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge mclk);
    checks++;
    if ({bclk, lrclk, sdata, src_if.sample_req, overrun} !== 5'b0 || fifo_level !== 2'd0 || underrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got b%b l%b s%b r%b o%b lvl%0d u%0d want all 0",
               bclk, lrclk, sdata, src_if.sample_req, overrun, fifo_level, underrun_cnt);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    wait_cnt(10);
    src_if.valid = 1'b1; src_if.p_sample_buffer = 16'h8001;
    exp_q.push_back(16'h8001);
    @(negedge mclk);
    src_if.valid = 1'b0;
    checks++;
    if (fifo_level !== 2'd1) begin errors++; $display("FAIL basic_level got %0d want 1", fifo_level); end
    wait_cnt(0);
    checks++;
    if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL basic_underrun got %0d want 0", underrun_cnt); end
    checks++;
    if (fifo_level !== 2'd0) begin errors++; $display("FAIL basic_pop_level got %0d want 0", fifo_level); end
    check_frame("basic");
  endtask

  task automatic test_underrun();
    wait_cnt(10);
    src_if.valid = 1'b1; src_if.p_sample_buffer = 16'h1234;
    @(negedge mclk);
    src_if.valid = 1'b0;
    clr_at(20);
    for (int k = 0; k < 4; k++) exp_q.push_back(16'h1234);
    for (int k = 0; k < 4; k++) begin
      wait_cnt(0);
      check_frame("underrun_repeat");
    end
    checks++;
    if (underrun_cnt !== 8'd3) begin errors++; $display("FAIL underrun_cnt got %0d want 3", underrun_cnt); end
  endtask

  task automatic test_overrun();
    clr_at(5);
    wait_cnt(10);
    src_if.valid = 1'b1; src_if.p_sample_buffer = 16'hAAAA;
    @(negedge mclk); src_if.p_sample_buffer = 16'h5555;
    @(negedge mclk); src_if.p_sample_buffer = 16'h7FFF;
    @(negedge mclk); src_if.valid = 1'b0;
    checks++;
    if (fifo_level !== 2'd2) begin errors++; $display("FAIL overrun_level got %0d want 2", fifo_level); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", overrun); end
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'h5555);
    wait_cnt(0); check_frame("overrun_first");
    wait_cnt(0); check_frame("overrun_second");
  endtask

  task automatic test_full_pop();
    clr_at(5);
    wait_cnt(10);
    src_if.valid = 1'b1; src_if.p_sample_buffer = 16'h1111;
    @(negedge mclk); src_if.p_sample_buffer = 16'h2222;
    @(negedge mclk); src_if.valid = 1'b0;
    wait_cnt(255);
    src_if.valid = 1'b1; src_if.p_sample_buffer = 16'h3333;
    @(negedge mclk); src_if.valid = 1'b0;
    checks++;
    if (fifo_level !== 2'd2) begin errors++; $display("FAIL fullpop_level got %0d want 2", fifo_level); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL fullpop_overrun got %b want 0", overrun); end
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    check_frame("fullpop_a");
    wait_cnt(0); check_frame("fullpop_b");
    wait_cnt(0); check_frame("fullpop_c");
  endtask

  task automatic test_clocks();
    int req_n = 0, lr_hi = 0, rises = 0, gap_err = 0, last_rise = -1;
    logic prev_b;
    wait_cnt(0);
    prev_b = bclk;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) @(negedge mclk);
      if (src_if.sample_req === 1'b1) req_n++;
      if (lrclk === 1'b1) lr_hi++;
      if (i > 0 && prev_b === 1'b0 && bclk === 1'b1) begin
        if (last_rise >= 0 && i - last_rise != 4) gap_err++;
        last_rise = i;
        rises++;
      end
      prev_b = bclk;
    end
    checks++;
    if (req_n !== 2) begin errors++; $display("FAIL clk_req_pulses got %0d want 2", req_n); end
    checks++;
    if (lr_hi !== 256) begin errors++; $display("FAIL clk_lrclk_high got %0d want 256", lr_hi); end
    checks++;
    if (rises !== 128 || gap_err !== 0) begin
      errors++; $display("FAIL clk_bclk rises %0d gaps_bad %0d want 128 and 0", rises, gap_err);
    end
  endtask

  task automatic test_saturate();
    clr_at(20);
    for (int k = 1; k <= 300; k++) begin
      wait_cnt(0);
      if (k == 254) begin
        checks++;
        if (underrun_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", underrun_cnt); end
      end
    end
    checks++;
    if (underrun_cnt !== 8'd255) begin errors++; $display("FAIL sat_max got %0d want 255", underrun_cnt); end
    clr_at(20);
    checks++;
    if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL sat_clear got %0d want 0", underrun_cnt); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    wait_cnt(10);
    src_if.valid = 1'b1; src_if.p_sample_buffer = 16'hF00F;
    repeat (3) @(negedge mclk);
    src_if.valid = 1'b0;
    wait_cnt(100);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bclk, lrclk, sdata, src_if.sample_req, overrun} !== 5'b0 || fifo_level !== 2'd0 || underrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midreset_async got b%b l%b s%b r%b o%b lvl%0d u%0d want all 0",
               bclk, lrclk, sdata, src_if.sample_req, overrun, fifo_level, underrun_cnt);
    end
    repeat (20) begin
      @(negedge mclk);
      if ({bclk, lrclk, sdata, src_if.sample_req, overrun} !== 5'b0 || fifo_level !== 2'd0 || underrun_cnt !== 8'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midreset_hold got %0d bad cycles want 0", bad); end
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge mclk);
      if (src_if.sample_req !== (tcnt == 8'd0) || bclk !== tcnt[1]) bad++;
      if (tcnt == 8'd0) break;
    end
    checks++;
    if (bad !== 0 || tcnt !== 8'd0) begin
      errors++; $display("FAIL midreset_restart got %0d bad cycles at cnt %0d want 0 at 0", bad, tcnt);
    end
    exp_q.push_back(16'h0000);
    check_frame("after_reset");
  endtask

  initial begin
    src_if.valid = 1'b0;
    src_if.p_sample_buffer = 16'h0;
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_full_pop();
    test_clocks();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
